// File: rtl/data_mem_wbuf.sv
// Data memory stage: single-port word RAM fronted by an in-order write buffer.
// Loads forward from the youngest buffered store. The buffer drains one entry on each cycle with no load.
module data_mem_wbuf #(
   parameter int MEM_AW     = 8,
   parameter int WBUF_DEPTH = 4,
   parameter int CNT_W      = 3
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic [31:0]      Addr,
   input  logic [31:0]      WD,
   input  logic             MemWrite,
   input  logic             MemRead,
   output logic [31:0]      Read_Data,
   output logic             Stall,
   output logic [CNT_W-1:0] Wb_count,
   output logic             Wb_empty
);

   localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;

   typedef struct packed {
      logic [MEM_AW-1:0] idx;
      logic [31:0]       data;
   } wb_entry_t;

   logic [31:0]           ram [2**MEM_AW];
   wb_entry_t             wb_mem [WBUF_DEPTH];
   logic [WBUF_DEPTH-1:0] wb_valid;
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;

   logic [MEM_AW-1:0]     word_idx;
   logic                  full;
   logic                  enq;
   logic                  drain;
   logic                  fwd_hit;
   logic [31:0]           fwd_data;

   // Byte offset and the address bits above the RAM are dropped, so high addresses alias.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{Addr[31:MEM_AW+2], Addr[1:0]};

   assign word_idx = Addr[MEM_AW+1:2];
   assign full     = (count == CNT_W'(WBUF_DEPTH));
   assign enq      = MemWrite && !full && !Reset;
   // The RAM has one port, so a load on this cycle blocks the drain.
   assign drain    = (count != '0) && !MemRead && !Reset;

   assign Stall    = MemWrite && full;
   assign Wb_count = count;
   assign Wb_empty = (count == '0);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         wb_valid <= '0;
      end else begin
         if (enq) begin
            wb_valid[wr_ptr] <= 1'b1;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (drain) begin
            wb_valid[rd_ptr] <= 1'b0;
            rd_ptr           <= rd_ptr + 1'b1;
         end
         case ({enq, drain})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: buffer payload and RAM are storage, not control state; they carry no reset.
   always_ff @(posedge CLK) begin
      if (enq)
         wb_mem[wr_ptr] <= '{idx: word_idx, data: WD};
   end

   always_ff @(posedge CLK) begin
      if (drain)
         ram[wb_mem[rd_ptr].idx] <= wb_mem[rd_ptr].data;
   end

   // Entries are scanned oldest to youngest, so the last match is the youngest store.
   // NOTE: every always_comb output is given a default first so no latch is inferred.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int i = 0; i < WBUF_DEPTH; i++) begin
         logic [PTR_W-1:0] slot;
         slot = rd_ptr + PTR_W'(i);
         if (wb_valid[slot] && (wb_mem[slot].idx == word_idx)) begin
            fwd_hit  = 1'b1;
            fwd_data = wb_mem[slot].data;
         end
      end
   end

   assign Read_Data = fwd_hit ? fwd_data : ram[word_idx];

endmodule
